usb_cdc_tx_sched: RTL and testbench
===================================

USB_CDC_TX_SCHED -- requirements
Module: usb_cdc_tx_sched

Interface
- REQ-001 SHALL have parameter AW, default 4: TX FIFO address width; level width.
- REQ-002 SHALL have parameter TW, default 16: idle-timeout counter width.
- REQ-003 SHALL have port clk, input, 1: the single clock; all state on rising edge.
- REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
- REQ-005 SHALL have port en_i, input, 1: scheduler enable.
- REQ-006 SHALL have port flush_i, input, 1: level-sensitive request to send immediately.
- REQ-007 SHALL have port burst_len_i, input, AW: bytes per burst; 0 is treated as 1.
- REQ-008 SHALL have port timeout_i, input, TW: idle cycles before a short burst is forced.
- REQ-009 SHALL have port fifo_empty_i, input, 1: TX FIFO empty (registered in FIFO).
- REQ-010 SHALL have port fifo_level_i, input, AW: TX FIFO occupancy.
- REQ-011 SHALL have port fifo_rd_o, output, 1: TX FIFO pop; equals in_valid_o & in_ready_i.
- REQ-012 SHALL have port in_valid_o, output, 1: valid toward the USB CDC IN endpoint.
- REQ-013 SHALL have port in_ready_i, input, 1: ready from the USB CDC IN endpoint.
- REQ-014 SHALL have port busy_o, output, 1: high when state is not IDLE.
- REQ-015 SHALL have port burst_done_o, output, 1: one-cycle pulse at burst end.
- REQ-016 SHALL have port short_o, output, 1: one-cycle pulse with burst_done_o when the burst was started by timeout or flush_i rather than by level.
- REQ-017 SHALL have port burst_cnt_o, output, 16: completed bursts; wraps from 65535 to 0.

Function
- REQ-018 SHALL implement states IDLE, COLLECT and BURST.
- REQ-019 IDLE: when en_i=1 and fifo_empty_i=0, SHALL go to COLLECT; timer is cleared to 0.
- REQ-020 COLLECT: timer SHALL increment by 1 per cycle and saturate at all-ones.
- REQ-021 COLLECT SHALL go to BURST when any of these holds: fifo_level_i >= effective burst_len; timer >= timeout_i; flush_i=1.
- REQ-022 COLLECT trigger priority SHALL be level > flush > timeout; the short flag is latched at BURST entry (0 for level, 1 otherwise).
- REQ-023 COLLECT with en_i=0 SHALL return to IDLE; no pops occur.
- REQ-024 timeout_i=0 SHALL start a burst on the first COLLECT cycle.
- REQ-025 BURST: in_valid_o SHALL equal ~fifo_empty_i; it is 0 in IDLE and COLLECT.
- REQ-026 Once in_valid_o is high, it SHALL stay high until in_ready_i is high; FIFO data is read combinationally, so the FIFO must not be emptied externally during BURST.
- REQ-027 Each handshake SHALL increment the 4-bit beat counter; the beat counter clears on BURST entry.
- REQ-028 A handshake that makes the beat count reach the effective burst_len SHALL take BURST to IDLE next cycle.
- REQ-029 BURST with fifo_empty_i=1 and beat count > 0 SHALL go to IDLE (early end).
- REQ-030 At BURST exit, burst_done_o (and short_o when the short flag is set) SHALL pulse for that cycle, and burst_cnt_o SHALL increment.
- REQ-031 en_i and flush_i SHALL be ignored in BURST; a burst always completes.
- REQ-032 Handshake latency: fifo_rd_o SHALL be combinational in the same cycle as the handshake; the state change is registered (1 cycle).
- REQ-033 The state after BURST SHALL always be IDLE for one cycle; back-to-back bursts are separated by at least 2 cycles (IDLE, COLLECT).

Reset
- REQ-034 rst_n=0 SHALL asynchronously force: state IDLE; timer 0; beat count 0; short flag 0; burst_cnt_o 0; in_valid_o, fifo_rd_o, busy_o, burst_done_o, short_o all 0.
- REQ-035 Reset during BURST SHALL abort the burst with no burst_done_o and no burst_cnt_o increment.
- REQ-036 Operation SHALL resume on the first clk edge after rst_n rises.

Structure
- REQ-037 State encoding (IDLE=0, COLLECT=1, BURST=2, 2 bits) SHALL live in the shared package usb_cdc_pkg, along with the default burst length constant (8).
- REQ-038 The timer SHALL be a sub-module usb_cdc_idle_timer (clear, enable, saturating count, TW wide); everything else stays in one module.

Verification
- REQ-039 Level trigger: burst_len=8, timeout=1000, write 8 bytes, in_ready=1 -> 8 consecutive fifo_rd_o, burst_done_o=1, short_o=0, burst_cnt_o=1.
- REQ-040 Timeout: burst_len=8, timeout=20, write 3 bytes -> burst starts 20 cycles after COLLECT entry, 3 pops, early end, short_o=1.
- REQ-041 Backpressure: in_ready toggling 1,0,0,1 during BURST -> in_valid_o held high and data stable across stalls, no pop when ready=0.
- REQ-042 Flush plus edge values: flush_i=1 with 1 byte, timeout=65535 -> burst next cycle, short_o=1; burst_len=0 -> exactly 1 byte per burst.
- REQ-043 Reset mid-burst: assert rst_n=0 after 2 of 8 beats -> all outputs 0 immediately, burst_cnt_o=0, no burst_done_o.
- REQ-044 Counter wrap: preload 65535 bursts (or force) then one more -> burst_cnt_o=0.

Source files
------------

// File: rtl/usb_cdc_pkg.sv
// ---------------------------------------------------------------------------
// usb_cdc_pkg
// Shared definitions for the USB CDC TX scheduler:
//   - scheduler state encoding (2 bits)
//   - default burst length and the beat-counter width derived from it
// ---------------------------------------------------------------------------
package usb_cdc_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_BURST   = 2'd2;

    localparam int DEFAULT_BURST_LEN = 8;

    // Beat counter is wide enough to count a default-length burst plus one
    // extra bit, which gives the 4-bit counter for the default of 8.
    localparam int BEAT_W = $clog2(DEFAULT_BURST_LEN) + 1;

endpackage

// File: rtl/usb_cdc_idle_timer.sv
// ---------------------------------------------------------------------------
// usb_cdc_idle_timer
// Saturating up-counter used to measure how long the scheduler has been
// collecting bytes without reaching a full burst.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear to 0 (wins over en_i)
//   en_i       : count enable, +1 per cycle, holds at all-ones
//   cnt_o      : current count, TW bits
// ---------------------------------------------------------------------------
module usb_cdc_idle_timer #(
    parameter int TW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [TW-1:0] cnt_o
);

    logic [TW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + TW'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/usb_cdc_tx_sched.sv
// ---------------------------------------------------------------------------
// usb_cdc_tx_sched
// Decides when bytes waiting in the TX FIFO are pushed to the USB CDC IN
// endpoint. Bytes are collected until a full burst is available, the idle
// timer expires, or a flush is requested; the burst is then streamed with a
// valid/ready handshake that pops the FIFO directly.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   en_i           : scheduler enable (only sampled in IDLE/COLLECT)
//   flush_i        : level-sensitive "send now" request
//   burst_len_i    : bytes per burst, 0 behaves as 1
//   timeout_i      : idle cycles in COLLECT before a short burst is forced
//   fifo_empty_i   : TX FIFO empty flag
//   fifo_level_i   : TX FIFO occupancy
//   fifo_rd_o      : TX FIFO pop (= in_valid_o & in_ready_i)
//   in_valid_o     : valid toward IN endpoint
//   in_ready_i     : ready from IN endpoint
//   busy_o         : scheduler not idle
//   burst_done_o   : one-cycle pulse in the last cycle of a burst
//   short_o        : with burst_done_o, burst was started by flush/timeout
//   burst_cnt_o    : completed bursts, wraps at 16 bits
// ---------------------------------------------------------------------------
module usb_cdc_tx_sched
    import usb_cdc_pkg::*;
#(
    parameter int AW = 4,
    parameter int TW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic          flush_i,
    input  logic [AW-1:0] burst_len_i,
    input  logic [TW-1:0] timeout_i,
    input  logic          fifo_empty_i,
    input  logic [AW-1:0] fifo_level_i,
    output logic          fifo_rd_o,
    output logic          in_valid_o,
    input  logic          in_ready_i,
    output logic          busy_o,
    output logic          burst_done_o,
    output logic          short_o,
    output logic [15:0]   burst_cnt_o
);

    // Common width for comparing the beat counter against the burst length.
    localparam int CW = (AW > BEAT_W) ? AW : BEAT_W;

    logic [1:0]        state_q, state_d;
    logic [BEAT_W-1:0] beat_q;
    logic [BEAT_W-1:0] beat_inc;
    logic              short_q;
    logic [15:0]       burst_cnt_q;
    logic [TW-1:0]     timer;

    logic [AW-1:0]     eff_len;
    logic              in_collect, in_burst;
    logic              hs;
    logic              level_hit, timeout_hit, trigger;
    logic              start_burst;
    logic              last_beat, early_end, burst_end;

    usb_cdc_idle_timer #(.TW(TW)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (~in_collect),
        .en_i  (in_collect),
        .cnt_o (timer)
    );

    assign eff_len    = (burst_len_i == '0) ? AW'(1) : burst_len_i;
    assign in_collect = (state_q == ST_COLLECT);
    assign in_burst   = (state_q == ST_BURST);

    // FIFO data is consumed combinationally: valid simply mirrors "not empty"
    // while bursting, and a handshake is the pop.
    assign in_valid_o = in_burst & ~fifo_empty_i;
    assign hs         = in_valid_o & in_ready_i;
    assign fifo_rd_o  = hs;

    // Trigger sources. Level has priority for the short flag: a burst is
    // only "short" if the FIFO did not already hold a full burst.
    assign level_hit   = (fifo_level_i >= eff_len);
    assign timeout_hit = (timer >= timeout_i);
    assign trigger     = level_hit | flush_i | timeout_hit;
    assign start_burst = in_collect & en_i & trigger;

    assign beat_inc  = beat_q + BEAT_W'(1);
    assign last_beat = hs & (CW'(beat_inc) == CW'(eff_len));
    // FIFO ran dry after at least one byte went out: close the burst short.
    assign early_end = in_burst & fifo_empty_i & (beat_q != '0);
    assign burst_end = in_burst & (last_beat | early_end);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (en_i && !fifo_empty_i) state_d = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (!en_i)        state_d = ST_IDLE;
                else if (trigger) state_d = ST_BURST;
            end
            ST_BURST: begin
                // en_i/flush_i deliberately ignored: a burst always completes.
                if (burst_end) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            short_q     <= 1'b0;
            burst_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (start_burst) begin
                beat_q  <= '0;
                short_q <= ~level_hit;
            end else if (hs) begin
                beat_q  <= beat_inc;
            end
            if (burst_end) begin
                burst_cnt_q <= burst_cnt_q + 16'd1;
            end
        end
    end

    assign busy_o       = (state_q != ST_IDLE);
    assign burst_done_o = burst_end;
    assign short_o      = burst_end & short_q;
    assign burst_cnt_o  = burst_cnt_q;

endmodule

// File: tb/tb_usb_cdc_tx_sched.sv
// ---------------------------------------------------------------------------
// tb_usb_cdc_tx_sched
// Directed bench for usb_cdc_tx_sched. A counter stands in for the TX FIFO
// (level/empty derived from it, decremented on each pop). A table of burst
// scenarios is run in a loop, followed by hand-written sequences for
// backpressure, enable drop, reset mid-burst and burst counter wrap.
// ---------------------------------------------------------------------------
module tb_usb_cdc_tx_sched;
    import usb_cdc_pkg::*;

    localparam int AW = 4;
    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en_i = 1'b0;
    logic          flush_i = 1'b0;
    logic [AW-1:0] burst_len_i = '0;
    logic [TW-1:0] timeout_i = '0;
    logic          fifo_empty_i;
    logic [AW-1:0] fifo_level_i;
    logic          fifo_rd_o;
    logic          in_valid_o;
    logic          in_ready_i = 1'b0;
    logic          busy_o;
    logic          burst_done_o;
    logic          short_o;
    logic [15:0]   burst_cnt_o;

    logic [AW-1:0] lvl = '0;
    logic [15:0]   exp_cnt = '0;
    int            n_tests = 0;
    int            n_fail = 0;

    assign fifo_empty_i = (lvl == '0);
    assign fifo_level_i = lvl;

    always #5 clk = ~clk;

    usb_cdc_tx_sched #(.AW(AW), .TW(TW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (en_i),
        .flush_i      (flush_i),
        .burst_len_i  (burst_len_i),
        .timeout_i    (timeout_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_level_i (fifo_level_i),
        .fifo_rd_o    (fifo_rd_o),
        .in_valid_o   (in_valid_o),
        .in_ready_i   (in_ready_i),
        .busy_o       (busy_o),
        .burst_done_o (burst_done_o),
        .short_o      (short_o),
        .burst_cnt_o  (burst_cnt_o)
    );

    typedef struct {
        logic [AW-1:0] blen;
        logic [TW-1:0] tmo;
        logic [AW-1:0] nbytes;
        logic          flush;
        int            exp_wait;   // COLLECT cycles before valid appears
        int            exp_pops;
        logic          exp_short;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    // Called at negedge+1 with inputs settled; returns at the next negedge+1.
    // The FIFO model pops right after the edge where a handshake happened.
    task automatic cyc();
        logic p;
        p = fifo_rd_o;
        @(posedge clk);
        #1;
        if (p) lvl = lvl - AW'(1);
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int c;
        c = 0;
        while (!in_valid_o && c < 100) begin
            cyc();
            c++;
        end
        chk(name, 32'(in_valid_o), 32'd1);
    endtask

    task automatic run_burst(input vec_t v, input string tag);
        int   wait_c, pops;
        logic seen, got, sh;
        burst_len_i = v.blen;
        timeout_i   = v.tmo;
        flush_i     = v.flush;
        lvl         = v.nbytes;
        in_ready_i  = 1'b1;
        en_i        = 1'b1;
        #1;
        wait_c = 0; pops = 0; seen = 0; got = 0; sh = 0;
        for (int c = 0; c < 300 && !got; c++) begin
            if (busy_o && !in_valid_o && !seen) wait_c++;
            if (in_valid_o) seen = 1'b1;
            if (fifo_rd_o) pops++;
            if (burst_done_o) begin
                got = 1'b1;
                sh  = short_o;
            end
            cyc();
        end
        en_i = 1'b0; flush_i = 1'b0; lvl = '0;
        #1;
        exp_cnt = exp_cnt + 16'd1;
        chk({tag, ".done"},  32'(got), 32'd1);
        chk({tag, ".wait"},  32'(wait_c), 32'(v.exp_wait));
        chk({tag, ".pops"},  32'(pops), 32'(v.exp_pops));
        chk({tag, ".short"}, 32'(sh), 32'(v.exp_short));
        chk({tag, ".cnt"},   32'(burst_cnt_o), 32'(exp_cnt));
        chk({tag, ".idle"},  32'(busy_o), 32'd0);
    endtask

    initial begin
        logic rdy_pat[6];
        //         blen               tmo     n   fl  wait pops short
        vecs[0] = '{AW'(DEFAULT_BURST_LEN), 16'd1000,  4'd8,  1'b0, 1,  8,  1'b0}; // level
        vecs[1] = '{AW'(DEFAULT_BURST_LEN), 16'd20,    4'd3,  1'b0, 21, 3,  1'b1}; // timeout, early end
        vecs[2] = '{AW'(DEFAULT_BURST_LEN), 16'd65535, 4'd1,  1'b1, 1,  1,  1'b1}; // flush
        vecs[3] = '{4'd0,                   16'd1000,  4'd3,  1'b0, 1,  1,  1'b0}; // len 0 -> 1
        vecs[4] = '{AW'(DEFAULT_BURST_LEN), 16'd0,     4'd2,  1'b0, 1,  2,  1'b1}; // timeout 0
        vecs[5] = '{4'd4,                   16'd1000,  4'd6,  1'b0, 1,  4,  1'b0}; // partial drain
        vecs[6] = '{4'd2,                   16'd1000,  4'd5,  1'b1, 1,  2,  1'b0}; // level beats flush
        vecs[7] = '{4'd15,                  16'd1000,  4'd15, 1'b0, 1,  15, 1'b0}; // max length

        // Reset state
        @(negedge clk); #1;
        chk("rst.valid", 32'(in_valid_o), 32'd0);
        chk("rst.rd",    32'(fifo_rd_o), 32'd0);
        chk("rst.busy",  32'(busy_o), 32'd0);
        chk("rst.done",  32'(burst_done_o), 32'd0);
        chk("rst.short", 32'(short_o), 32'd0);
        chk("rst.cnt",   32'(burst_cnt_o), 32'd0);
        rst_n = 1'b1;
        cyc();

        for (int i = 0; i < 8; i++) begin
            run_burst(vecs[i], $sformatf("vec%0d", i));
            cyc();
        end

        // Backpressure: ready 1,0,0,1,1,1 on a 4-byte burst
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        burst_len_i = 4'd4; timeout_i = 16'd1000; lvl = 4'd4;
        in_ready_i = 1'b0; en_i = 1'b1;
        #1;
        wait_valid("bp.start");
        for (int i = 0; i < 6; i++) begin
            in_ready_i = rdy_pat[i];
            #1;
            chk($sformatf("bp%0d.valid", i), 32'(in_valid_o), 32'd1);
            chk($sformatf("bp%0d.rd", i),    32'(fifo_rd_o), 32'(rdy_pat[i]));
            chk($sformatf("bp%0d.done", i),  32'(burst_done_o), 32'(i == 5));
            cyc();
        end
        en_i = 1'b0; in_ready_i = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        #1;
        chk("bp.lvl",  32'(lvl), 32'd0);
        chk("bp.busy", 32'(busy_o), 32'd0);
        chk("bp.cnt",  32'(burst_cnt_o), 32'(exp_cnt));
        cyc();

        // Enable dropped while collecting: back to IDLE, nothing popped
        burst_len_i = 4'd8; timeout_i = 16'd1000; lvl = 4'd3;
        in_ready_i = 1'b1; en_i = 1'b1;
        #1;
        cyc();
        chk("endrop.busy1", 32'(busy_o), 32'd1);
        chk("endrop.valid", 32'(in_valid_o), 32'd0);
        en_i = 1'b0;
        #1;
        cyc();
        chk("endrop.busy0", 32'(busy_o), 32'd0);
        chk("endrop.lvl",   32'(lvl), 32'd3);
        lvl = '0;
        cyc();

        // Reset after 2 of 8 beats
        burst_len_i = 4'd8; timeout_i = 16'd1000; lvl = 4'd8;
        in_ready_i = 1'b1; en_i = 1'b1;
        #1;
        wait_valid("mrst.start");
        cyc();
        cyc();
        chk("mrst.lvl", 32'(lvl), 32'd6);
        rst_n = 1'b0;
        #1;
        chk("mrst.valid", 32'(in_valid_o), 32'd0);
        chk("mrst.rd",    32'(fifo_rd_o), 32'd0);
        chk("mrst.busy",  32'(busy_o), 32'd0);
        chk("mrst.done",  32'(burst_done_o), 32'd0);
        chk("mrst.short", 32'(short_o), 32'd0);
        chk("mrst.cnt",   32'(burst_cnt_o), 32'd0);
        exp_cnt = '0;
        en_i = 1'b0; lvl = '0;
        @(negedge clk); #1;
        rst_n = 1'b1;
        cyc();
        chk("mrst.after", 32'(burst_cnt_o), 32'd0);

        // Operation resumes after reset
        run_burst('{4'd1, 16'd1000, 4'd1, 1'b0, 1, 1, 1'b0}, "resume");
        cyc();

        // Counter wrap: preload 65535, one more burst wraps to 0
        force dut.burst_cnt_q = 16'hFFFF;
        #1;
        release dut.burst_cnt_q;
        #1;
        exp_cnt = 16'hFFFF;
        chk("wrap.pre", 32'(burst_cnt_o), 32'hFFFF);
        run_burst('{4'd0, 16'd1000, 4'd1, 1'b0, 1, 1, 1'b0}, "wrap");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
